uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters (fixed at 4 for this release).
REQ-002 Parameter: START_TIMEOUT, 16, max cycles to wait for tx_active after tx_start is asserted.
REQ-003 Clocking is decided: one clock; reset is synchronous and active-low.
REQ-004 Port: clock  in  1  single rising-edge clock.
REQ-005 Port: reset_n  in  1  synchronous active-low reset.
REQ-006 Port: req  in  4  per-requester send request, held high until granted.
REQ-007 Port: req_data  in  32  byte of requester i on bits [8i+7:8i].
REQ-008 Port: req_baud  in  12  baud select of requester i on bits [3i+2:3i].
REQ-009 Port: grant  out  4  one-hot, 1-cycle pulse; the byte of that requester is captured.
REQ-010 Port: done  out  4  one-hot, 1-cycle pulse; that requester's byte finished (stop bit sent).
REQ-011 Port: err  out  1  1-cycle pulse on start timeout.
REQ-012 Port: busy  out  1  high whenever the FSM is not IDLE.
REQ-013 Port: tx_start  out  1  start strobe to the UART transmitter.
REQ-014 Port: tx_byte  out  8  byte to the UART transmitter.
REQ-015 Port: tx_baud  out  3  baud select to the UART transmitter.
REQ-016 Port: tx_active  in  1  transmitter busy flag.
REQ-017 Port: tx_done  in  1  transmitter completion flag (high for 2 cycles after the stop bit).

Function
REQ-018 The FSM SHALL have the states IDLE, ARB, START, BUSY and GAP; the encoding is implementation choice.
REQ-019 IDLE: when any req bit is high, the FSM SHALL go to ARB next cycle; otherwise it SHALL stay in IDLE.
REQ-020 ARB SHALL pick the winner round-robin, searching from index (last+1) mod 4 upward.
REQ-021 In ARB, the winner's req_data and req_baud SHALL be latched into tx_byte and tx_baud, its grant bit pulsed, last set to winner, and the FSM SHALL go to START.
REQ-022 If req is all zero in ARB (request withdrawn), there SHALL be no grant and the FSM SHALL return to IDLE.
REQ-023 START: tx_start SHALL be high every cycle in START; when tx_active=1, the FSM SHALL go to BUSY with tx_start low from the next cycle.
REQ-024 START timeout: if tx_active stays 0 for START_TIMEOUT cycles in START, tx_start SHALL drop, err SHALL pulse once, there SHALL be no done pulse, and the FSM SHALL go to IDLE.
REQ-025 BUSY: on the rising edge of tx_done (current 1, previous 0), done[last] SHALL pulse for 1 cycle and the FSM SHALL go to GAP.
REQ-026 GAP: the FSM SHALL hold until tx_done=0 and tx_active=0, then go to IDLE; no new start SHALL issue in GAP.
REQ-027 tx_byte and tx_baud SHALL stay constant from ARB through GAP; tx_baud SHALL never change while tx_active=1.
REQ-028 Minimum turnaround: IDLE->ARB->START SHALL take 2 cycles from req to tx_start; there SHALL be no back-to-back issue without passing IDLE.
REQ-029 Requests arriving while busy SHALL wait; a held req SHALL never be lost, and each requester SHALL be served within 4 transactions.
REQ-030 At most one grant bit and at most one done bit SHALL be high in any cycle.
REQ-031 The timeout counter SHALL be 5 bits, cleared on entry to START, and SHALL saturate without wrapping.

Reset
REQ-032 While reset_n=0 at a clock edge: state IDLE; grant, done, err, tx_start = 0; tx_byte=0x00; tx_baud=3'b000; busy=0; last=3 (requester 0 wins first); timeout counter = 0.
REQ-033 Reset mid-transaction SHALL abandon it with no done and no err pulse; the external transmitter is reset by its own reset.

Verification
REQ-034 Single request: req=0001, data0=0xA5, baud0=3'b111 -> grant=0001 one cycle, tx_start 2 cycles after req, tx_byte=0xA5, tx_baud=7, done=0001 once after the stop bit.
REQ-035 All four requesting continuously -> grant order 0,1,2,3,0, each followed by its done before the next grant.
REQ-036 Model the transmitter with tx_active tied to 0 -> tx_start high for 16 cycles, err pulse, no done, FSM back in IDLE, next request served.
REQ-037 Drive req=0100 for 1 cycle only, dropped in the ARB cycle -> no grant, FSM returns to IDLE.
REQ-038 Assert reset_n=0 in BUSY during data bits -> all outputs at reset values next edge, no done; after release req1 is served normally.
REQ-039 Change req_baud while BUSY -> tx_baud unchanged until the next ARB.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ requesters.
// It issues a start strobe with a bounded wait for the transmitter, and pulses grant, done and err per transaction.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ*3-1:0] req_baud,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic                 busy,
  output logic                 tx_start,
  output logic [7:0]           tx_byte,
  output logic [2:0]           tx_baud,
  input  logic                 tx_active,
  input  logic                 tx_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [4:0] TMO_LAST = 5'(START_TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [IDX_W-1:0]   last_r;
  logic [IDX_W-1:0]   winner_s;
  logic [4:0]         cnt_r;
  logic               tx_done_prev_r;
  logic [NUM_REQ-1:0] grant_r;
  logic [NUM_REQ-1:0] done_r;
  logic               err_r;
  logic               busy_r;
  logic               tx_start_r;
  logic [7:0]         tx_byte_r;
  logic [2:0]         tx_baud_r;
  logic [NUM_REQ-1:0] grant_s;
  logic [NUM_REQ-1:0] done_s;
  logic               err_s;
  logic               load_s;
  logic               cnt_clr_s;
  logic               cnt_inc_s;
  logic [7:0]         sel_byte_s;
  logic [2:0]         sel_baud_s;

  // First requester found scanning upward from the one after the previous winner.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic             found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx   = last + IDX_W'(k);
      pick  = (!found && r[idx]) ? idx : pick;
      found = found | r[idx];
    end
    return pick;
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? 5'd31 : v + 5'd1;
  endfunction

  assign winner_s = rr_pick(req, last_r);

  // Byte and baud of the current round-robin winner.
  always_comb begin
    sel_byte_s = 8'h00;
    sel_baud_s = 3'b000;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_byte_s = (winner_s == IDX_W'(i)) ? req_data[i*8 +: 8] : sel_byte_s;
      sel_baud_s = (winner_s == IDX_W'(i)) ? req_baud[i*3 +: 3] : sel_baud_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-cycle event decode.
  always_comb begin
    next_state_s = state_r;
    grant_s      = {NUM_REQ{1'b0}};
    done_s       = {NUM_REQ{1'b0}};
    err_s        = 1'b0;
    load_s       = 1'b0;
    cnt_clr_s    = 1'b0;
    cnt_inc_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          next_state_s = ST_ARB;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ARB: begin
        if (|req) begin
          next_state_s = ST_START;
          grant_s      = ONE_HOT0 << winner_s;
          load_s       = 1'b1;
          cnt_clr_s    = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tx_active) begin
          next_state_s = ST_BUSY;
        end else if (cnt_r >= TMO_LAST) begin
          next_state_s = ST_IDLE;
          err_s        = 1'b1;
        end else begin
          next_state_s = ST_START;
          cnt_inc_s    = 1'b1;
        end
      end
      ST_BUSY: begin
        if (tx_done && !tx_done_prev_r) begin
          next_state_s = ST_GAP;
          done_s       = ONE_HOT0 << last_r;
        end else begin
          next_state_s = ST_BUSY;
        end
      end
      ST_GAP: begin
        if (!tx_done && !tx_active) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Registered outputs, captured transfer parameters and start-wait counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      grant_r        <= {NUM_REQ{1'b0}};
      done_r         <= {NUM_REQ{1'b0}};
      err_r          <= 1'b0;
      busy_r         <= 1'b0;
      tx_start_r     <= 1'b0;
      tx_byte_r      <= 8'h00;
      tx_baud_r      <= 3'b000;
      last_r         <= IDX_W'(NUM_REQ - 1);
      cnt_r          <= 5'd0;
      tx_done_prev_r <= 1'b0;
    end else begin
      grant_r        <= grant_s;
      done_r         <= done_s;
      err_r          <= err_s;
      busy_r         <= (next_state_s != ST_IDLE);
      tx_start_r     <= (next_state_s == ST_START);
      tx_done_prev_r <= tx_done;
      if (load_s) begin
        tx_byte_r <= sel_byte_s;
        tx_baud_r <= sel_baud_s;
        last_r    <= winner_s;
      end
      if (cnt_clr_s) begin
        cnt_r <= 5'd0;
      end else if (cnt_inc_s) begin
        cnt_r <= sat_inc(cnt_r);
      end
    end
  end

  assign grant    = grant_r;
  assign done     = done_r;
  assign err      = err_r;
  assign busy     = busy_r;
  assign tx_start = tx_start_r;
  assign tx_byte  = tx_byte_r;
  assign tx_baud  = tx_baud_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a transaction-level round-robin model plus a simple transmitter responder.
// Directed scenarios come first, then randomized request patterns.
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [11:0] req_baud;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        err;
  logic        busy;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic [2:0]  tx_baud;
  logic        tx_active;
  logic        tx_done;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] data_m [4];
  logic [2:0] baud_m [4];
  logic [3:0] pend;
  int         last_m;
  int         age [4];

  int x_state = 0;
  int x_cnt   = 0;
  bit x_dead  = 1'b0;

  logic       prev_active = 1'b0;
  logic [2:0] prev_baud   = 3'b000;

  uart_tx_arbiter #(.NUM_REQ(4), .START_TIMEOUT(16)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .req_data (req_data),
    .req_baud (req_baud),
    .grant    (grant),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .tx_start (tx_start),
    .tx_byte  (tx_byte),
    .tx_baud  (tx_baud),
    .tx_active(tx_active),
    .tx_done  (tx_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] m, input int last);
    int i;
    for (int k = 1; k <= 4; k++) begin
      i = (last + k) % 4;
      if (m[i]) return i;
    end
    return 0;
  endfunction

  task automatic drive();
    req = pend;
    for (int i = 0; i < 4; i++) begin
      req_data[i*8 +: 8] = data_m[i];
      req_baud[i*3 +: 3] = baud_m[i];
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("back_to_idle", busy, 1'b0);
  endtask

  // One full transaction: expected winner from the model, then its done.
  task automatic run_txn(input bit keep);
    int         w;
    int         n;
    bit         extra;
    bit         fair;
    logic [7:0] eb;
    logic [2:0] ebd;
    w = rr_pick(pend, last_m);
    n = 0;
    while (grant === 4'd0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("grant_seen", grant != 4'd0, 1'b1);
    chk("grant", grant, 4'b0001 << w);
    chk("tx_byte_at_grant", tx_byte, data_m[w]);
    chk("tx_baud_at_grant", tx_baud, baud_m[w]);
    chk("tx_start_at_grant", tx_start, 1'b1);
    fair = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (pend[i] && i != w) begin
        age[i]++;
        if (age[i] > 3) fair = 1'b0;
      end
    end
    age[w] = 0;
    chk("fairness", fair, 1'b1);
    eb     = data_m[w];
    ebd    = baud_m[w];
    last_m = w;
    if (!keep) pend[w] = 1'b0;
    data_m[w] = 8'($urandom);
    baud_m[w] = 3'($urandom);
    drive();
    extra = 1'b0;
    n     = 0;
    @(negedge clock);
    while (done === 4'd0 && n < 100) begin
      if (grant !== 4'd0) extra = 1'b1;
      @(negedge clock);
      n++;
    end
    chk("done", done, 4'b0001 << w);
    chk("no_grant_before_done", extra, 1'b0);
    chk("tx_byte_held", tx_byte, eb);
    chk("tx_baud_held", tx_baud, ebd);
    chk("no_err", err, 1'b0);
  endtask

  // Transmitter responder: optional start latency, a data phase, then tx_done for two cycles.
  initial begin
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset_n) begin
        tx_active = 1'b0;
        tx_done   = 1'b0;
        x_state   = 0;
      end else begin
        case (x_state)
          0: if (tx_start && !x_dead) begin x_cnt = $urandom_range(0, 3); x_state = 1; end
          1: if (x_cnt == 0) begin tx_active = 1'b1; x_cnt = $urandom_range(3, 10); x_state = 2; end
             else x_cnt--;
          2: if (x_cnt == 0) begin tx_active = 1'b0; tx_done = 1'b1; x_state = 3; end
             else x_cnt--;
          3: x_state = 4;
          4: begin tx_done = 1'b0; x_state = 0; end
          default: x_state = 0;
        endcase
      end
    end
  end

  // Cycle invariants: one-hot pulses and a stable baud while transmitting.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      chk("grant_onehot0", (grant & (grant - 4'd1)) == 4'd0, 1'b1);
      chk("done_onehot0", (done & (done - 4'd1)) == 4'd0, 1'b1);
      if (prev_active && tx_active) chk("baud_stable_active", tx_baud, prev_baud);
    end
    prev_active = tx_active;
    prev_baud   = tx_baud;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n;
    logic [3:0] nw;
    reset_n  = 1'b0;
    pend     = 4'd0;
    last_m   = 3;
    for (int i = 0; i < 4; i++) begin
      data_m[i] = 8'($urandom);
      baud_m[i] = 3'($urandom);
      age[i]    = 0;
    end
    drive();
    repeat (3) @(negedge clock);
    chk("rst_grant", grant, 4'd0);
    chk("rst_done", done, 4'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_tx_baud", tx_baud, 3'b000);
    reset_n = 1'b1;
    @(negedge clock);

    // All four held: order 0,1,2,3,0 from reset.
    pend = 4'b1111;
    drive();
    for (int j = 0; j < 5; j++) begin
      run_txn(1'b1);
      chk("rr_order", last_m, j % 4);
    end
    pend = 4'd0;
    drive();
    wait_idle();

    // Single request with two-cycle turnaround.
    pend      = 4'b0001;
    data_m[0] = 8'hA5;
    baud_m[0] = 3'b111;
    drive();
    @(negedge clock);
    chk("single_arb_grant", grant, 4'd0);
    chk("single_arb_start", tx_start, 1'b0);
    chk("single_arb_busy", busy, 1'b1);
    @(negedge clock);
    chk("single_grant", grant, 4'b0001);
    chk("single_start", tx_start, 1'b1);
    chk("single_byte", tx_byte, 8'hA5);
    chk("single_baud", tx_baud, 3'd7);
    run_txn(1'b0);
    wait_idle();

    // Request withdrawn during arbitration.
    pend = 4'b0100;
    drive();
    @(negedge clock);
    chk("wd_busy_arb", busy, 1'b1);
    pend = 4'd0;
    drive();
    @(negedge clock);
    chk("wd_busy", busy, 1'b0);
    chk("wd_grant", grant, 4'd0);
    @(negedge clock);
    chk("wd_grant_late", grant, 4'd0);
    chk("wd_start", tx_start, 1'b0);

    // Dead transmitter: start timeout.
    x_dead = 1'b1;
    pend   = 4'b0010;
    drive();
    n = 0;
    while (grant === 4'd0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("tmo_grant", grant, 4'b0010);
    last_m = 1;
    pend   = 4'd0;
    drive();
    n = 0;
    while (tx_start === 1'b1 && n < 40) begin
      n++;
      @(negedge clock);
    end
    chk("tmo_start_cycles", n, 16);
    chk("tmo_err", err, 1'b1);
    chk("tmo_no_done", done, 4'd0);
    chk("tmo_idle", busy, 1'b0);
    @(negedge clock);
    chk("tmo_err_pulse", err, 1'b0);
    x_dead = 1'b0;
    pend   = 4'b1000;
    drive();
    run_txn(1'b0);
    wait_idle();

    // Reset while the byte is being sent.
    pend = 4'b0001;
    drive();
    n = 0;
    while (grant === 4'd0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("rb_grant", grant, 4'b0001);
    pend = 4'd0;
    drive();
    n = 0;
    while (tx_active !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("rb_active_seen", tx_active, 1'b1);
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("rb_grant0", grant, 4'd0);
    chk("rb_done0", done, 4'd0);
    chk("rb_err0", err, 1'b0);
    chk("rb_start0", tx_start, 1'b0);
    chk("rb_busy0", busy, 1'b0);
    chk("rb_byte0", tx_byte, 8'h00);
    chk("rb_baud0", tx_baud, 3'b000);
    reset_n = 1'b1;
    last_m  = 3;
    repeat (4) begin
      @(negedge clock);
      chk("rb_no_done", done, 4'd0);
      chk("rb_no_err", err, 1'b0);
    end
    pend = 4'b0010;
    drive();
    run_txn(1'b0);
    wait_idle();

    // Randomized request patterns against the round-robin model.
    for (int i = 0; i < 4; i++) age[i] = 0;
    for (int t = 0; t < 20; t++) begin
      nw = 4'($urandom) & ~pend;
      if ((pend | nw) == 4'd0) nw = 4'b0001 << $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin
        if (nw[i]) age[i] = 0;
      end
      pend = pend | nw;
      drive();
      run_txn(1'b0);
    end
    pend = 4'd0;
    drive();
    wait_idle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
